// File: rtl/ibex_pkg.sv
// Shared definitions for the register-file write-back arbiter.
package ibex_pkg;

    localparam int unsigned ADDR_WIDTH   = 5;
    localparam int unsigned ADDR_WIDTH_E = 4;

    typedef enum logic {
        RfWbIdle     = 1'b0,
        RfWbLoadPend = 1'b1
    } rf_wb_state_e;

    // Number of significant register-address bits (RV32E has 16 registers).
    function automatic int unsigned rf_addr_width(bit rv32e);
        return rv32e ? ADDR_WIDTH_E : ADDR_WIDTH;
    endfunction

endpackage

// File: rtl/ibex_rf_fwd_reg.sv
// One-entry forward register: holds the last register-file write for one
// cycle and overrides the raw read data on both read ports while the latch
// file cannot yet show the new value.
module ibex_rf_fwd_reg #(
    parameter int unsigned AW        = 5,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [4:0]           waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o
);

    logic                 r_fwd_v;
    logic [4:0]           r_fwd_addr;
    logic [DataWidth-1:0] r_fwd_data;
    logic                 w_hit_a;
    logic                 w_hit_b;

    // Capture every cycle's write, so the entry is valid exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fwd_v    <= 1'b0;
            r_fwd_addr <= '0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_v    <= we_i;
            r_fwd_addr <= waddr_i;
            r_fwd_data <= wdata_i;
        end
    end

    assign w_hit_a = r_fwd_v && (r_fwd_addr[AW-1:0] == raddr_a_i[AW-1:0])
                             && (raddr_a_i[AW-1:0] != '0);
    assign w_hit_b = r_fwd_v && (r_fwd_addr[AW-1:0] == raddr_b_i[AW-1:0])
                             && (raddr_b_i[AW-1:0] != '0);

    assign rdata_a_o = w_hit_a ? r_fwd_data : rf_rdata_a_i;
    assign rdata_b_o = w_hit_b ? r_fwd_data : rf_rdata_b_i;

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Write-back arbiter in front of the latch register file: merges execute
// results with late load data (load wins), tracks the single outstanding
// load destination for RAW/WAW hazards and forwards the last write.
module ibex_rf_wb_arbiter
    import ibex_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_we_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_issue_i,
    input  logic [4:0]           lsu_rd_i,
    output logic                 lsu_issue_ready_o,
    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic                 stall_raw_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o
);

    localparam int unsigned AW = rf_addr_width(RV32E);

    rf_wb_state_e r_state, w_state_d;
    logic [4:0]   r_pend_rd, w_pend_rd_d;
    logic         w_pend;
    logic         w_rsp;
    logic         w_rsp_ok;
    logic         w_pend_nz;
    logic         w_waw;

    assign w_pend    = (r_state == RfWbLoadPend);
    // A response only counts while a load is outstanding; stray ones after
    // a reset are dropped.
    assign w_rsp     = w_pend && lsu_rvalid_i;
    assign w_rsp_ok  = w_rsp && !lsu_err_i;
    assign w_pend_nz = (r_pend_rd[AW-1:0] != '0);
    assign w_waw     = w_pend && !lsu_rvalid_i
                     && (ex_waddr_i[AW-1:0] == r_pend_rd[AW-1:0]);

    assign ex_ready_o        = !w_rsp_ok && !w_waw;
    assign lsu_issue_ready_o = !w_pend || lsu_rvalid_i;
    assign stall_raw_o       = w_pend && !lsu_rvalid_i && w_pend_nz
                             && ((raddr_a_i[AW-1:0] == r_pend_rd[AW-1:0])
                              || (raddr_b_i[AW-1:0] == r_pend_rd[AW-1:0]));

    // State and pending destination register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= RfWbIdle;
            r_pend_rd <= '0;
        end else begin
            r_state   <= w_state_d;
            r_pend_rd <= w_pend_rd_d;
        end
    end

    // Next state: a response with a same-cycle issue keeps the FSM pending.
    always_comb begin
        w_state_d   = r_state;
        w_pend_rd_d = r_pend_rd;
        case (r_state)
            RfWbIdle: begin
                if (lsu_issue_i) begin
                    w_state_d   = RfWbLoadPend;
                    w_pend_rd_d = lsu_rd_i;
                end
            end
            RfWbLoadPend: begin
                if (lsu_rvalid_i) begin
                    if (lsu_issue_i) begin
                        w_pend_rd_d = lsu_rd_i;
                    end else begin
                        w_state_d = RfWbIdle;
                    end
                end
            end
            default: w_state_d = RfWbIdle;
        endcase
    end

    // Write mux: load data first, then an accepted execute result; x0 never.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = ex_waddr_i;
        rf_wdata_o = ex_wdata_i;
        if (w_rsp_ok) begin
            rf_we_o    = w_pend_nz;
            rf_waddr_o = r_pend_rd;
            rf_wdata_o = lsu_rdata_i;
        end else if (ex_we_i && ex_ready_o && (ex_waddr_i[AW-1:0] != '0)) begin
            rf_we_o = 1'b1;
        end
    end

    ibex_rf_fwd_reg #(
        .AW        (AW),
        .DataWidth (DataWidth)
    ) u_fwd (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .we_i         (rf_we_o),
        .waddr_i      (rf_waddr_o),
        .wdata_i      (rf_wdata_o),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .rf_rdata_a_i (rf_rdata_a_i),
        .rf_rdata_b_i (rf_rdata_b_i),
        .rdata_a_o    (rdata_a_o),
        .rdata_b_o    (rdata_b_o)
    );

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed bench: expected register-file writes go into a scoreboard queue,
// a negedge monitor pops and compares every rf_we_o; handshake, stall and
// forwarding outputs are compared inline.
module tb_ibex_rf_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ex_we_i = 1'b0;
    logic [4:0]  ex_waddr_i = 5'd1;
    logic [31:0] ex_wdata_i = '0;
    logic        lsu_issue_i = 1'b0;
    logic [4:0]  lsu_rd_i = '0;
    logic        lsu_rvalid_i = 1'b0;
    logic [31:0] lsu_rdata_i = '0;
    logic        lsu_err_i = 1'b0;
    logic [4:0]  raddr_a_i = '0, raddr_b_i = '0;
    logic [31:0] rf_rdata_a_i = '0, rf_rdata_b_i = '0;

    logic        ex_ready_o, lsu_issue_ready_o, stall_raw_o, rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o, rdata_a_o, rdata_b_o;

    logic        e_ex_ready, e_issue_ready, e_stall, e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_rdata_a, e_rdata_b;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    wr_t q[$];
    wr_t mon_e;

    always #5 clk_i = ~clk_i;

    ibex_rf_wb_arbiter #(.RV32E(1'b0), .DataWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready_o),
        .lsu_issue_i(lsu_issue_i), .lsu_rd_i(lsu_rd_i), .lsu_issue_ready_o(lsu_issue_ready_o),
        .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
        .stall_raw_o(stall_raw_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
    );

    ibex_rf_wb_arbiter #(.RV32E(1'b1), .DataWidth(32)) dut_e (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(e_ex_ready),
        .lsu_issue_i(lsu_issue_i), .lsu_rd_i(lsu_rd_i), .lsu_issue_ready_o(e_issue_ready),
        .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .rdata_a_o(e_rdata_a), .rdata_b_o(e_rdata_b),
        .stall_raw_o(e_stall),
        .rf_we_o(e_we), .rf_waddr_o(e_waddr), .rf_wdata_o(e_wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        q.push_back(w);
    endtask

    // Scoreboard monitor: every write must match the next expected one.
    always @(negedge clk_i) begin
        if (rf_we_o === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h expected no write",
                         rf_waddr_o, rf_wdata_o);
            end else begin
                mon_e = q.pop_front();
                chk("wr_addr", {27'b0, rf_waddr_o}, {27'b0, mon_e.a});
                chk("wr_data", rf_wdata_o, mon_e.d);
            end
        end
    end

    initial begin
        // Reset values
        cyc(); cyc();
        @(negedge clk_i);
        chk("rst_we", rf_we_o, 0);
        chk("rst_ex_ready", ex_ready_o, 1);
        chk("rst_issue_ready", lsu_issue_ready_o, 1);
        chk("rst_stall", stall_raw_o, 0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // Execute write x5 then forward for exactly one cycle
        ex_we_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hDEADBEEF;
        push(5, 32'hDEADBEEF);
        @(negedge clk_i);
        chk("ex_ready_basic", ex_ready_o, 1);
        cyc();
        ex_we_i = 0; raddr_a_i = 5; rf_rdata_a_i = 32'h0;
        @(negedge clk_i);
        chk("fwd_a", rdata_a_o, 32'hDEADBEEF);
        cyc();
        rf_rdata_a_i = 32'h11111111;
        @(negedge clk_i);
        chk("fwd_expired", rdata_a_o, 32'h11111111);
        cyc();
        raddr_a_i = 0;

        // Load to x7: RAW stall for 3 cycles, response clears it
        lsu_issue_i = 1; lsu_rd_i = 7;
        @(negedge clk_i);
        chk("issue_ready_idle", lsu_issue_ready_o, 1);
        cyc();
        lsu_issue_i = 0; raddr_b_i = 7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("stall_raw", stall_raw_o, 1);
            chk("issue_ready_pend", lsu_issue_ready_o, 0);
            cyc();
        end
        lsu_rvalid_i = 1; lsu_rdata_i = 32'h1234;
        push(7, 32'h1234);
        @(negedge clk_i);
        chk("stall_drop", stall_raw_o, 0);
        cyc();
        lsu_rvalid_i = 0; rf_rdata_b_i = 32'h0;
        @(negedge clk_i);
        chk("fwd_load_b", rdata_b_o, 32'h1234);
        cyc();
        raddr_b_i = 0;

        // Load response to x3 collides with execute write to x4
        lsu_issue_i = 1; lsu_rd_i = 3;
        cyc();
        lsu_issue_i = 0; lsu_rvalid_i = 1; lsu_rdata_i = 32'h33;
        ex_we_i = 1; ex_waddr_i = 4; ex_wdata_i = 32'h44;
        push(3, 32'h33);
        @(negedge clk_i);
        chk("ex_ready_collide", ex_ready_o, 0);
        cyc();
        lsu_rvalid_i = 0;
        push(4, 32'h44);
        @(negedge clk_i);
        chk("ex_ready_after", ex_ready_o, 1);
        cyc();
        ex_we_i = 0;

        // WAW: execute to x9 held until the x9 load response
        lsu_issue_i = 1; lsu_rd_i = 9;
        cyc();
        lsu_issue_i = 0; ex_we_i = 1; ex_waddr_i = 9; ex_wdata_i = 32'h99;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("waw_hold", ex_ready_o, 0);
            cyc();
        end
        lsu_rvalid_i = 1; lsu_rdata_i = 32'h90;
        push(9, 32'h90);
        @(negedge clk_i);
        chk("waw_rsp", ex_ready_o, 0);
        cyc();
        lsu_rvalid_i = 0;
        push(9, 32'h99);
        @(negedge clk_i);
        chk("waw_release", ex_ready_o, 1);
        cyc();
        ex_we_i = 0; ex_waddr_i = 1;

        // Errored load: no write, back to idle
        lsu_issue_i = 1; lsu_rd_i = 6;
        cyc();
        lsu_issue_i = 0; lsu_rvalid_i = 1; lsu_err_i = 1; lsu_rdata_i = 32'hBAD;
        @(negedge clk_i);
        chk("err_no_we", rf_we_o, 0);
        chk("err_ex_ready", ex_ready_o, 1);
        cyc();
        lsu_rvalid_i = 0; lsu_err_i = 0; raddr_a_i = 6;
        @(negedge clk_i);
        chk("err_idle", lsu_issue_ready_o, 1);
        chk("err_no_stall", stall_raw_o, 0);
        cyc();
        raddr_a_i = 0;

        // x0 writes suppressed for both sources
        ex_we_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'hFFFF;
        @(negedge clk_i);
        chk("x0_ex", rf_we_o, 0);
        cyc();
        ex_we_i = 0; ex_waddr_i = 1;
        lsu_issue_i = 1; lsu_rd_i = 0;
        cyc();
        lsu_issue_i = 0;
        @(negedge clk_i);
        chk("x0_no_stall", stall_raw_o, 0);
        cyc();
        lsu_rvalid_i = 1; lsu_rdata_i = 32'h77;
        @(negedge clk_i);
        chk("x0_load", rf_we_o, 0);
        cyc();
        lsu_rvalid_i = 0;

        // Back-to-back loads x10 then x11
        lsu_issue_i = 1; lsu_rd_i = 10;
        cyc();
        lsu_rvalid_i = 1; lsu_rdata_i = 32'hAA; lsu_rd_i = 11;
        push(10, 32'hAA);
        @(negedge clk_i);
        chk("b2b_issue_ready", lsu_issue_ready_o, 1);
        cyc();
        lsu_issue_i = 0; lsu_rvalid_i = 0; raddr_a_i = 11;
        @(negedge clk_i);
        chk("b2b_stall", stall_raw_o, 1);
        cyc();
        lsu_rvalid_i = 1; lsu_rdata_i = 32'hBB;
        push(11, 32'hBB);
        cyc();
        lsu_rvalid_i = 0; raddr_a_i = 0;

        // Reset mid-load, then stray response ignored
        lsu_issue_i = 1; lsu_rd_i = 12;
        cyc();
        lsu_issue_i = 0; rst_ni = 0;
        cyc();
        rst_ni = 1;
        lsu_rvalid_i = 1; lsu_rdata_i = 32'hCC; raddr_a_i = 12;
        @(negedge clk_i);
        chk("stray_we", rf_we_o, 0);
        chk("stray_ex_ready", ex_ready_o, 1);
        chk("stray_issue_ready", lsu_issue_ready_o, 1);
        chk("stray_stall", stall_raw_o, 0);
        cyc();
        lsu_rvalid_i = 0; raddr_a_i = 0;

        // RV32E: bit 4 of the address ignored
        lsu_issue_i = 1; lsu_rd_i = 5;
        cyc();
        lsu_issue_i = 0; raddr_a_i = 5'h15;
        @(negedge clk_i);
        chk("rv32e_stall", e_stall, 1);
        chk("rv32i_no_stall", stall_raw_o, 0);
        cyc();
        lsu_rvalid_i = 1; lsu_rdata_i = 32'h5555;
        push(5, 32'h5555);
        cyc();
        lsu_rvalid_i = 0; rf_rdata_a_i = 32'h0;
        @(negedge clk_i);
        chk("rv32e_fwd", e_rdata_a, 32'h5555);
        chk("rv32i_no_fwd", rdata_a_o, 32'h0);
        cyc();

        chk("sb_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
